pcs_40g_tx_sched: RTL

Slot scheduler for the 40GBASE-R PCS transmit path; sits between the MAC-side interface and the `pcs_40g_tx` encode/scramble/gearbox datapath. Each cycle in which the gearbox can accept data is one block slot on all four lanes. The scheduler assigns every slot as either an alignment-marker slot or a data slot, throttles the MAC with `ready_o`, and tells the datapath when to insert idles. It also flags illegal gearbox stall runs.

---
 rtl/pcs_40g_pkg.sv | 16 +
 rtl/pcs_stall_mon.sv | 47 ++++
 rtl/pcs_40g_tx_sched.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pcs_40g_pkg.sv
// pcs_40g_pkg: shared definitions for the 40GBASE-R PCS transmit path.
//   sched_state_e  : slot scheduler FSM states
//   AM_PERIOD_40G  : slots per alignment-marker period (1 marker + data slots)
//   LANE_N         : PCS lanes served by every slot
package pcs_40g_pkg;

  typedef enum logic [1:0] {
    RST      = 2'd0,
    FIRST_AM = 2'd1,
    RUN      = 2'd2
  } sched_state_e;

  localparam int AM_PERIOD_40G = 16384;
  localparam int LANE_N        = 4;

endpackage

// File: rtl/pcs_stall_mon.sv
// pcs_stall_mon: gearbox stall-run monitor.
// Counts consecutive stall cycles (saturating at STALL_MAX) and raises a
// sticky error once the run reaches STALL_MAX. Only a reset clears the error.
// Ports:
//   clk      in   clock
//   nreset   in   synchronous active-low reset
//   en_i     in   monitoring enabled (scheduler out of reset state)
//   stall_i  in   gearbox stall this cycle
//   err_o    out  sticky stall-run error
module pcs_stall_mon #(
  parameter int STALL_MAX = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic en_i,
  input  logic stall_i,
  output logic err_o
);

  localparam int            CW  = $clog2(STALL_MAX + 1);
  localparam logic [CW-1:0] SAT = CW'(STALL_MAX);

  logic [CW-1:0] stall_d, stall_q;
  logic          err_d, err_q;

  always_comb begin
    stall_d = '0;
    if (en_i && stall_i) begin
      stall_d = (stall_q == SAT) ? stall_q : stall_q + CW'(1);
    end
    // Error latches in the same edge the run count hits the limit.
    err_d = err_q | (stall_d == SAT);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/pcs_40g_tx_sched.sv
// pcs_40g_tx_sched: slot scheduler for the 40GBASE-R PCS transmit path.
// Every cycle the gearbox is not stalled is one block slot on all lanes. The
// slot carries alignment markers when one is pending, otherwise data; the MAC
// is throttled with ready_o and idles are requested when it has no data.
// Optional feature macro: PCS_40G_AM_FORCE_EN adds am_force_i, which requests
// an out-of-schedule marker while running.
// Ports:
//   clk          in   clock
//   nreset       in   synchronous active-low reset
//   valid_i      in   MAC presents a 4-lane block group
//   gb_stall_i   in   gearbox cannot accept a block this cycle
//   am_force_i   in   (PCS_40G_AM_FORCE_EN only) force a marker next slot
//   ready_o      out  MAC group consumed when valid_i & ready_o
//   am_v_o       out  current slot carries alignment markers
//   blk_v_o      out  current slot is a data slot
//   idle_ins_o   out  data slot without MAC data; insert idles
//   stall_err_o  out  sticky gearbox stall-run error
module pcs_40g_tx_sched
  import pcs_40g_pkg::*;
#(
  parameter int AM_PERIOD = AM_PERIOD_40G,
  parameter int STALL_MAX = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic valid_i,
  input  logic gb_stall_i,
`ifdef PCS_40G_AM_FORCE_EN
  input  logic am_force_i,
`endif
  output logic ready_o,
  output logic am_v_o,
  output logic blk_v_o,
  output logic idle_ins_o,
  output logic stall_err_o
);

  localparam int               CNT_W    = $clog2(AM_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AM_PERIOD - 2);

  sched_state_e     state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             am_pend_d, am_pend_q;
  logic             slot, force_req;

`ifdef PCS_40G_AM_FORCE_EN
  assign force_req = am_force_i & (state_q == RUN);
`else
  assign force_req = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= RST;
      cnt_q     <= '0;
      am_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      am_pend_q <= am_pend_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RST:      state_d = FIRST_AM;
      FIRST_AM: if (slot) state_d = RUN;
      RUN:      state_d = RUN;
      default:  state_d = RST;
    endcase
  end

  // Slot decode; all outputs follow gb_stall_i in the same cycle.
  always_comb begin
    slot       = (state_q != RST) & ~gb_stall_i;
    am_v_o     = slot & am_pend_q;
    blk_v_o    = slot & ~am_pend_q;
    ready_o    = blk_v_o;
    idle_ins_o = blk_v_o & ~valid_i;
  end

  // Marker period counter and pending flag
  always_comb begin
    cnt_d     = cnt_q;
    am_pend_d = am_pend_q;
    if (state_q == RST) begin
      // Entering FIRST_AM: the very first slot is a marker.
      cnt_d     = '0;
      am_pend_d = 1'b1;
    end else if (am_v_o) begin
      cnt_d     = '0;
      am_pend_d = 1'b0;
    end else if (blk_v_o) begin
      // The last data slot of a period holds the count so it never reaches
      // AM_PERIOD-1; the marker that follows reloads zero.
      if (cnt_q == CNT_LAST) begin
        am_pend_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (force_req) am_pend_d = 1'b1;
    end else if (force_req) begin
      // Stalled cycle: the counter holds, a force is still remembered.
      am_pend_d = 1'b1;
    end
  end

  pcs_stall_mon #(
    .STALL_MAX(STALL_MAX)
  ) u_stall_mon (
    .clk    (clk),
    .nreset (nreset),
    .en_i   (state_q != RST),
    .stall_i(gb_stall_i),
    .err_o  (stall_err_o)
  );

endmodule
